salsa_mix_unit: RTL and testbench

Iterated Salsa20/8 core for the scrypt SMix datapath. It takes the two 512-bit BlockMix halves X0 and X1 and produces Xmix = Salsa20/8(X0 ^ X1) after three clock edges. The engine FSM drives the mixfeedback control and steers Xmix back into X0/X1 and the scratchpad address. The block also specifies the 256-bit-wide scratchpad RAM slice the engine instantiates four times.

---
 rtl/salsa_mix_unit_pkg.sv | 57 +++++
 rtl/salsa_mix_unit_ram.sv | 32 +++
 rtl/salsa_mix_unit.sv | 41 ++++
 tb/tb_salsa_mix_unit.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/salsa_mix_unit_pkg.sv
// Salsa20 word/block types and the quarter-round / double-round functions
// shared by the mix unit, the scratchpad slice and any debug model.
package salsa_mix_unit_pkg;

    localparam int WORD   = 32;
    localparam int BLOCK  = 512;
    localparam int NWORDS = BLOCK / WORD;
    localparam int RAM_W  = 256;

    typedef logic [WORD-1:0]       word_t;
    typedef word_t [NWORDS-1:0]    blk_t;
    typedef logic [3:0]            widx_t;

    typedef enum logic {
        MIX_LOAD = 1'b0,
        MIX_ITER = 1'b1
    } mix_mode_e;

    function automatic word_t rotl(input word_t x, input int unsigned n);
        return (x << n) | (x >> (WORD - n));
    endfunction

    function automatic blk_t qr(input blk_t x, input widx_t a, input widx_t b,
                                input widx_t c, input widx_t d);
        blk_t y;
        y    = x;
        y[b] = y[b] ^ rotl(y[a] + y[d], 7);
        y[c] = y[c] ^ rotl(y[b] + y[a], 9);
        y[d] = y[d] ^ rotl(y[c] + y[b], 13);
        y[a] = y[a] ^ rotl(y[d] + y[c], 18);
        return y;
    endfunction

    // Column pass then row pass: one Salsa20 double round.
    function automatic blk_t dr(input blk_t x);
        blk_t y;
        y = qr(x, 4'd0,  4'd4,  4'd8,  4'd12);
        y = qr(y, 4'd5,  4'd9,  4'd13, 4'd1);
        y = qr(y, 4'd10, 4'd14, 4'd2,  4'd6);
        y = qr(y, 4'd15, 4'd3,  4'd7,  4'd11);
        y = qr(y, 4'd0,  4'd1,  4'd2,  4'd3);
        y = qr(y, 4'd5,  4'd6,  4'd7,  4'd4);
        y = qr(y, 4'd10, 4'd11, 4'd8,  4'd9);
        y = qr(y, 4'd15, 4'd12, 4'd13, 4'd14);
        return y;
    endfunction

    function automatic blk_t add_words(input blk_t a, input blk_t b);
        blk_t r;
        r = '0;
        for (int i = 0; i < NWORDS; i++) begin
            r[i] = a[i] + b[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/salsa_mix_unit_ram.sv
// 256-bit scratchpad slice: addr/din/we registered, dout combinational from the
// registered address (one-cycle read latency, a write cycle shows the old word).
module scratchpad_ram
    import salsa_mix_unit_pkg::*;
#(
    parameter int ADDRBITS = 10
) (
    input  logic [ADDRBITS-1:0] addr,
    input  logic                clk,
    input  logic [RAM_W-1:0]    din,
    input  logic                we,
    output logic [RAM_W-1:0]    dout
);

    logic [RAM_W-1:0]    mem [0:(1<<ADDRBITS)-1];
    logic [ADDRBITS-1:0] addr_q;
    logic [RAM_W-1:0]    din_q;
    logic                we_q;

    // The write lands one edge after capture, so the read in the capture cycle sees old data.
    always_ff @(posedge clk) begin
        addr_q <= addr;
        din_q  <= din;
        we_q   <= we;
        if (we_q) begin
            mem[addr_q] <= din_q;
        end
    end

    assign dout = mem[addr_q];

endmodule

// File: rtl/salsa_mix_unit.sv
// Iterated Salsa20/8: load edge then two feedback edges, Xmix valid after the third edge.
// No handshake; the engine owns the schedule via mixfeedback and samples Xmix on edge k+3.
module salsa_mix_unit
    import salsa_mix_unit_pkg::*;
(
    input  logic             hash_clk,
    input  logic             reset,
    input  logic             mixfeedback,
    input  logic [BLOCK-1:0] X0,
    input  logic [BLOCK-1:0] X1,
    output logic [BLOCK-1:0] Xmix
);

    blk_t      inp;
    blk_t      st;
    blk_t      x_in;
    blk_t      dr_in;
    blk_t      dr_next;
    mix_mode_e mode;

    assign mode    = mix_mode_e'(mixfeedback);
    assign x_in    = X0 ^ X1;
    assign dr_in   = (mode == MIX_LOAD) ? x_in : st;
    assign dr_next = dr(dr_in);

    always_ff @(posedge hash_clk or posedge reset) begin
        if (reset) begin
            inp <= '0;
            st  <= '0;
        end else begin
            st <= dr_next;
            if (mode == MIX_LOAD) begin
                inp <= x_in;
            end
        end
    end

    // Fourth double round and feed-forward sit after the registers to save a cycle.
    assign Xmix = add_words(inp, dr(st));

endmodule

// File: tb/tb_salsa_mix_unit.sv
module tb_salsa_mix_unit;

    logic         hash_clk = 1'b0;
    logic         reset;
    logic         mixfeedback;
    logic [511:0] X0;
    logic [511:0] X1;
    logic [511:0] Xmix;

    logic [9:0]   r_addr;
    logic [255:0] r_din;
    logic         r_we;
    logic [255:0] r_dout;

    always #5 hash_clk = ~hash_clk;

    salsa_mix_unit dut (
        .hash_clk   (hash_clk),
        .reset      (reset),
        .mixfeedback(mixfeedback),
        .X0         (X0),
        .X1         (X1),
        .Xmix       (Xmix)
    );

    scratchpad_ram #(.ADDRBITS(10)) ram (
        .addr(r_addr),
        .clk (hash_clk),
        .din (r_din),
        .we  (r_we),
        .dout(r_dout)
    );

    // Byte-order listings from the reference vectors (first byte leftmost).
    localparam logic [511:0] IN8_BYTES = 512'h7e879a214f3ec9867ca940e641718f26_baee555b8c61c1b50df846116dcd3b1d_ee24f319df9b3d8514121e4b5ac5aa32_76021d2909c74829edebc68db8b8c25e;
    localparam logic [511:0] B0_BYTES  = 512'hf7ce0b653d2d72a4108cf5abe912ffdd_777616dbbb27a70e8204f3ae2d0f6fad_89f68f4811d1e87bcc3bd7400a9ffd29_094f0184639574f39ae5a1315217bcd7;
    localparam logic [511:0] B1_BYTES  = 512'h894991447213bb226c25b54da86370fb_cd984380374666bb8ffcb5bf40c254b0_67d27c51ce4ad5fed829c90b505a571b_7f4d1cad6a523cda770e67bceaaf7e89;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    int quad [0:7][0:3] = '{
        '{0, 4, 8, 12}, '{5, 9, 13, 1}, '{10, 14, 2, 6}, '{15, 3, 7, 11},
        '{0, 1, 2, 3},  '{5, 6, 7, 4},  '{10, 11, 8, 9}, '{15, 12, 13, 14}
    };

    function automatic logic [511:0] le(input logic [511:0] s);
        logic [511:0] r;
        for (int k = 0; k < 64; k++) r[8*k +: 8] = s[511-8*k -: 8];
        return r;
    endfunction

    function automatic logic [31:0] rl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    // in + (ndr double rounds of in), word-wise; ndr=4 is Salsa20/8.
    function automatic logic [511:0] ref_mix(input logic [511:0] in, input int ndr);
        logic [31:0]  x [16];
        logic [31:0]  w [16];
        logic [511:0] r;
        int a, b, c, d;
        for (int i = 0; i < 16; i++) begin
            x[i] = in[32*i +: 32];
            w[i] = x[i];
        end
        for (int n = 0; n < ndr; n++) begin
            for (int q = 0; q < 8; q++) begin
                a = quad[q][0]; b = quad[q][1]; c = quad[q][2]; d = quad[q][3];
                x[b] = x[b] ^ rl(x[a] + x[d], 7);
                x[c] = x[c] ^ rl(x[b] + x[a], 9);
                x[d] = x[d] ^ rl(x[c] + x[b], 13);
                x[a] = x[a] ^ rl(x[d] + x[c], 18);
            end
        end
        for (int i = 0; i < 16; i++) r[32*i +: 32] = x[i] + w[i];
        return r;
    endfunction

    task automatic check512(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_ne(input string name, input logic [511:0] act, input logic [511:0] bad);
        n_cmp++;
        if (act === bad) begin
            n_bad++;
            $display("FAIL %s: got %h, must differ from %h", name, act, bad);
        end
    endtask

    // Model: Xmix = in + DR^(feedbacks+2)(in) since the last load; reset makes in = 0.
    logic [511:0] m_in = '0;
    int           m_fb = 0;

    always @(posedge hash_clk or posedge reset) begin
        if (reset) begin
            m_in = '0;
            m_fb = 0;
        end else if (!mixfeedback) begin
            m_in = X0 ^ X1;
            m_fb = 0;
        end else begin
            m_fb = m_fb + 1;
        end
    end

    always @(negedge hash_clk) begin
        if (chk_en) check512("xmix_vs_model", Xmix, ref_mix(m_in, m_fb + 2));
    end

    task automatic cyc(input logic mf);
        mixfeedback = mf;
        @(negedge hash_clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [511:0] in8, b0, b1, exp8, y0, y1;
        in8  = le(IN8_BYTES);
        b0   = le(B0_BYTES);
        b1   = le(B1_BYTES);
        exp8 = ref_mix(in8, 4);

        reset = 1'b0; mixfeedback = 1'b0; X0 = '0; X1 = '0;
        r_addr = '0; r_din = '0; r_we = 1'b0;
        #1 reset = 1'b1;
        repeat (2) @(negedge hash_clk);
        check512("reset_xmix", Xmix, '0);
        reset  = 1'b0;
        chk_en = 1'b1;

        check32("model_rotl", rl(32'h80000001, 7), 32'h000000c0);
        check32("model_rfc8_w0", exp8[31:0], 32'h9c851fa4);
        check32("vec_b0_xor_b1", b0[31:0] ^ b1[31:0], in8[31:0]);

        cyc(1'b0); cyc(1'b1); cyc(1'b1);
        check512("zero_input", Xmix, '0);

        X0 = in8; X1 = '0;
        cyc(1'b0); cyc(1'b1); cyc(1'b1);
        check32("rfc8_w0", Xmix[31:0], 32'h9c851fa4);
        check512("rfc8_full", Xmix, exp8);

        cyc(1'b1);
        check_ne("overiter_changes", Xmix, exp8);
        cyc(1'b0); cyc(1'b1); cyc(1'b1);
        check512("reload_after_overiter", Xmix, exp8);

        y0 = ref_mix(b0 ^ b1, 4);
        X0 = b0; X1 = b1;
        cyc(1'b0); cyc(1'b1); cyc(1'b1);
        check512("blockmix_half0", Xmix, y0);
        check32("blockmix_half0_w0", Xmix[31:0], 32'h9c851fa4);
        y1 = ref_mix(b1 ^ y0, 4);
        X0 = b1; X1 = y0;
        cyc(1'b0); cyc(1'b1); cyc(1'b1);
        check512("blockmix_half1", Xmix, y1);

        X0 = in8; X1 = '0;
        cyc(1'b0);
        #2 reset = 1'b1;
        #1 check512("reset_midflight", Xmix, '0);
        @(negedge hash_clk);
        check512("reset_held", Xmix, '0);
        reset = 1'b0;
        cyc(1'b0); cyc(1'b1); cyc(1'b1);
        check512("load_after_reset", Xmix, exp8);

        chk_en = 1'b0;
        r_addr = 10'd3; r_din = {32{8'hA5}}; r_we = 1'b1;
        @(negedge hash_clk);
        r_addr = 10'd1023; r_din = {32{8'h5A}};
        @(negedge hash_clk);
        r_we = 1'b0; r_addr = 10'd3;
        @(negedge hash_clk);
        check512("ram_read_3", {256'b0, r_dout}, {256'b0, {32{8'hA5}}});
        r_addr = 10'd1023;
        @(negedge hash_clk);
        check512("ram_read_1023", {256'b0, r_dout}, {256'b0, {32{8'h5A}}});
        r_addr = 10'd3; r_din = {32{8'h3C}}; r_we = 1'b1;
        @(negedge hash_clk);
        check512("ram_write_returns_old", {256'b0, r_dout}, {256'b0, {32{8'hA5}}});
        r_we = 1'b0;
        @(negedge hash_clk);
        check512("ram_read_new", {256'b0, r_dout}, {256'b0, {32{8'h3C}}});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
